// File: rtl/register_file.sv
// LEGv8 architectural register file: X0-X30 stored, X31 (XZR) hard-wired to zero; two read ports, one write port.
// Latency: reads combinational (0 cycles); writes land on the rising clock edge and are visible after it.
// No backpressure; one write per cycle. Define REGFILE_BYPASS_EN to forward same-cycle write data to A/B.
module register_file #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic [ADDR_W-1:0] DA,
    input  logic              W,
    input  logic [WIDTH-1:0]  D,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] XZR = '1;

    // The top entry is XZR and has no storage behind it.
    logic [WIDTH-1:0] r_regs [0:NREG-2];

    logic             w_wr_en;
    logic             w_sa_zr;
    logic             w_sb_zr;
    logic [WIDTH-1:0] w_a_store;
    logic [WIDTH-1:0] w_b_store;

    assign w_wr_en = W && (DA != XZR);
    assign w_sa_zr = (SA == XZR);
    assign w_sb_zr = (SB == XZR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[DA] <= D;
        end
    end

    always_comb begin
        w_a_store = '0;
        w_b_store = '0;
        if (!w_sa_zr) begin
            w_a_store = r_regs[SA];
        end
        if (!w_sb_zr) begin
            w_b_store = r_regs[SB];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // Forwarding is gated by reset so outputs stay zero while reset is held.
    assign w_byp_a = reset_n && w_wr_en && (SA == DA);
    assign w_byp_b = reset_n && w_wr_en && (SB == DA);

    assign A = w_byp_a ? D : w_a_store;
    assign B = w_byp_b ? D : w_b_store;
`else
    assign A = w_a_store;
    assign B = w_b_store;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed table plus corner-case sequences and a shadow-model random run for register_file.
module tb_register_file;

    logic        clock;
    logic        reset_n;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  DA;
    logic        W;
    logic [63:0] D;
    logic [63:0] A;
    logic [63:0] B;

    int n_checks = 0;
    int n_fail   = 0;

    register_file #(.WIDTH(64), .ADDR_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .SA      (SA),
        .SB      (SB),
        .DA      (DA),
        .W       (W),
        .D       (D),
        .A       (A),
        .B       (B)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [4:0]  da;
        logic [63:0] d;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [63:0] exp_a;  // value before the edge, no-forwarding build
        logic [63:0] exp_b;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Forwarding build: a same-cycle write to the selected register shows through.
    function automatic logic [63:0] fwd(input logic [4:0] sel, input logic [63:0] base,
                                        input logic w, input logic [4:0] da, input logic [63:0] d);
`ifdef REGFILE_BYPASS_EN
        if (w && da != 5'd31 && sel == da) return d;
`endif
        return base;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [63:0] shadow [32];

    initial begin
        vecs[0]  = '{1'b1, 5'd1,  64'd15,         5'd1,  5'd2,  64'd0,  64'd0};
        vecs[1]  = '{1'b1, 5'd2,  64'd2,          5'd1,  5'd2,  64'd15, 64'd0};
        vecs[2]  = '{1'b0, 5'd0,  64'd0,          5'd1,  5'd2,  64'd15, 64'd2};
        vecs[3]  = '{1'b0, 5'd0,  64'd0,          5'd1,  5'd1,  64'd15, 64'd15};
        vecs[4]  = '{1'b1, 5'd31, 64'hDEADBEEF,   5'd31, 5'd1,  64'd0,  64'd15};
        vecs[5]  = '{1'b0, 5'd0,  64'd0,          5'd31, 5'd31, 64'd0,  64'd0};
        vecs[6]  = '{1'b1, 5'd3,  64'd7,          5'd3,  5'd0,  64'd0,  64'd0};
        vecs[7]  = '{1'b1, 5'd3,  64'd9,          5'd3,  5'd3,  64'd7,  64'd7};
        vecs[8]  = '{1'b0, 5'd0,  64'd0,          5'd3,  5'd2,  64'd9,  64'd2};
        vecs[9]  = '{1'b1, 5'd5,  64'hA,          5'd5,  5'd5,  64'd0,  64'd0};
        vecs[10] = '{1'b1, 5'd5,  64'hB,          5'd5,  5'd1,  64'hA,  64'd15};
        vecs[11] = '{1'b0, 5'd0,  64'd0,          5'd5,  5'd1,  64'hB,  64'd15};
        vecs[12] = '{1'b1, 5'd30, '1,             5'd30, 5'd0,  64'd0,  64'd0};
        vecs[13] = '{1'b0, 5'd0,  64'd0,          5'd30, 5'd31, '1,     64'd0};

        reset_n = 1'b0;
        SA = '0; SB = '0; DA = '0; W = 1'b0; D = '0;

        // Reset held: every address reads zero on both ports.
        #2;
        for (int i = 0; i < 32; i++) begin
            SA = 5'(i);
            SB = 5'(31 - i);
            #1;
            chk("rst_sweep_a", A, 64'd0);
            chk("rst_sweep_b", B, 64'd0);
        end

        // A write edge during reset is discarded, and forwarding stays off.
        W = 1'b1; DA = 5'd5; D = 64'hFFFF; SA = 5'd5; SB = 5'd5;
        #1;
        chk("rst_nofwd_a", A, 64'd0);
        tick();
        W = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        chk("rst_wr_drop", A, 64'd0);
        tick();

        // Directed table: check before the edge, then clock the write in.
        for (int i = 0; i < 14; i++) begin
            W = vecs[i].w; DA = vecs[i].da; D = vecs[i].d;
            SA = vecs[i].sa; SB = vecs[i].sb;
            #3;
            chk($sformatf("vec%0d_a", i), A,
                fwd(vecs[i].sa, vecs[i].exp_a, vecs[i].w, vecs[i].da, vecs[i].d));
            chk($sformatf("vec%0d_b", i), B,
                fwd(vecs[i].sb, vecs[i].exp_b, vecs[i].w, vecs[i].da, vecs[i].d));
            tick();
        end
        W = 1'b0;

        // Load Xn = n, then pulse reset between edges.
        for (int i = 0; i < 31; i++) begin
            W = 1'b1; DA = 5'(i); D = 64'(i);
            tick();
        end
        W = 1'b0;
        SA = 5'd7; SB = 5'd30;
        #1;
        chk("load_x7", A, 64'd7);
        chk("load_x30", B, 64'd30);
        reset_n = 1'b0;
        #1;
        chk("async_rst_a", A, 64'd0);
        chk("async_rst_b", B, 64'd0);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            SA = 5'(i);
            SB = 5'(31 - i);
            #0.1;
            chk("post_rst_a", A, 64'd0);
            chk("post_rst_b", B, 64'd0);
        end
        tick();
        W = 1'b1; DA = 5'd4; D = 64'h8000000000000000;
        tick();
        W = 1'b0; SA = 5'd4; SB = 5'd3;
        #1;
        chk("x4_msb", A, 64'h8000000000000000);
        chk("x3_clear", B, 64'd0);

        // Random run against a shadow model; current contents are all zero except X4.
        for (int i = 0; i < 32; i++) shadow[i] = 64'd0;
        shadow[4] = 64'h8000000000000000;
        for (int c = 0; c < 1000; c++) begin
            logic [63:0] ea;
            logic [63:0] eb;
            tick();
            SA = 5'($urandom_range(0, 31));
            SB = 5'($urandom_range(0, 31));
            DA = 5'($urandom_range(0, 31));
            W  = 1'($urandom_range(0, 1));
            D  = {$urandom, $urandom};
            #3;
            ea = (SA == 5'd31) ? 64'd0 : shadow[SA];
            eb = (SB == 5'd31) ? 64'd0 : shadow[SB];
            chk("rand_a", A, fwd(SA, ea, W, DA, D));
            chk("rand_b", B, fwd(SB, eb, W, DA, D));
            if (W && DA != 5'd31) shadow[DA] = D;
        end
        tick();
        W = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
